fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch controller: decodes debug-UART command bytes, streams program loads into
// instruction memory and gates the program counter for run / single-step.
// Optional load watchdog enabled by defining FETCH_CTRL_TIMEOUT_EN.
module fetch_ctrl #(
  parameter int unsigned NB_MEM_WIDTH   = 8,
  parameter int unsigned NB_IMEM_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_rx_valid,
  input  logic                     i_halt,
  output logic                     o_write_enable,
  output logic [NB_MEM_WIDTH-1:0]  o_write_data,
  output logic [NB_IMEM_DEPTH-1:0] o_write_addr,
  output logic                     o_instru_mem_enable,
  output logic                     o_read_enable,
  output logic                     o_pc_enable,
  output logic                     o_pc_reset,
  output logic                     o_load_done,
  output logic                     o_busy,
  output logic                     o_error
);

  localparam logic [7:0] CmdLoad  = 8'h4C;
  localparam logic [7:0] CmdRun   = 8'h52;
  localparam logic [7:0] CmdStep  = 8'h53;
  localparam logic [7:0] CmdReset = 8'h58;

  typedef enum logic [2:0] {StIdle, StLoadLen, StLoadData, StRun, StStep} state_e;

  state_e                   state_q, state_d;
  logic [9:0]               cnt_q, cnt_d;
  logic [NB_IMEM_DEPTH-1:0] addr_q, addr_d;
  logic                     we_q, we_d;
  logic [NB_MEM_WIDTH-1:0]  wdata_q, wdata_d;
  logic [NB_IMEM_DEPTH-1:0] waddr_q, waddr_d;
  logic                     mem_en_q, mem_en_d;
  logic                     rd_en_q, rd_en_d;
  logic                     pc_en_q, pc_en_d;
  logic                     pc_rst_q, pc_rst_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;

`ifdef FETCH_CTRL_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0] wdog_q, wdog_d;
  logic           error_q, error_d;
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    waddr_d  = waddr_q;
    mem_en_d = 1'b1;
    rd_en_d  = 1'b0;
    pc_en_d  = 1'b0;
    pc_rst_d = 1'b0;
    done_d   = 1'b0;
`ifdef FETCH_CTRL_TIMEOUT_EN
    wdog_d   = '0;
    error_d  = error_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CmdLoad: begin
              state_d = StLoadLen;
`ifdef FETCH_CTRL_TIMEOUT_EN
              error_d = 1'b0;
`endif
            end
            CmdRun: begin
              state_d = StRun;
              pc_en_d = 1'b1;
              rd_en_d = 1'b1;
            end
            CmdStep: begin
              state_d = StStep;
              pc_en_d = 1'b1;
              rd_en_d = 1'b1;
            end
            CmdReset: pc_rst_d = 1'b1;
            default: ;
          endcase
        end
      end
      StLoadLen: begin
        if (i_rx_valid) begin
          cnt_d  = {i_rx_data, 2'b00};
          addr_d = '0;
          if (i_rx_data == 8'h00) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StLoadData;
          end
        end
      end
      StLoadData: begin
        if (i_rx_valid) begin
          we_d    = 1'b1;
          wdata_d = NB_MEM_WIDTH'(i_rx_data);
          waddr_d = addr_q;
          addr_d  = addr_q + 1'b1;
          cnt_d   = cnt_q - 10'd1;
          if (cnt_q == 10'd1) begin
            state_d  = StIdle;
            done_d   = 1'b1;
            pc_rst_d = 1'b1;
          end
        end
      end
      StRun: begin
        // Halt and an 'X' byte both stop the run; halt needs no byte decode.
        if (i_halt || (i_rx_valid && i_rx_data == CmdReset)) begin
          state_d = StIdle;
        end else begin
          pc_en_d = 1'b1;
          rd_en_d = 1'b1;
        end
      end
      StStep: state_d = StIdle;
      default: state_d = StIdle;
    endcase
`ifdef FETCH_CTRL_TIMEOUT_EN
    // Watchdog counts idle cycles inside a load; expiry aborts without load_done.
    if ((state_q == StLoadLen || state_q == StLoadData) && !i_rx_valid) begin
      if (wdog_q == WdW'(TIMEOUT_CYCLES - 1)) begin
        state_d = StIdle;
        error_d = 1'b1;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
`endif
    busy_d = (state_d != StIdle);
  end

  // State, counters and output registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      waddr_q  <= '0;
      mem_en_q <= 1'b0;
      rd_en_q  <= 1'b0;
      pc_en_q  <= 1'b0;
      pc_rst_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      waddr_q  <= waddr_d;
      mem_en_q <= mem_en_d;
      rd_en_q  <= rd_en_d;
      pc_en_q  <= pc_en_d;
      pc_rst_q <= pc_rst_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

`ifdef FETCH_CTRL_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wdog_q  <= '0;
      error_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      error_q <= error_d;
    end
  end
  assign o_error = error_q;
`else
  assign o_error = 1'b0;
`endif

  assign o_write_enable      = we_q;
  assign o_write_data        = wdata_q;
  assign o_write_addr        = waddr_q;
  assign o_instru_mem_enable = mem_en_q;
  assign o_read_enable       = rd_en_q;
  assign o_pc_enable         = pc_en_q;
  assign o_pc_reset          = pc_rst_q;
  assign o_load_done         = done_q;
  assign o_busy              = busy_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a default-depth instance and a 2-bit-address
// instance share stimulus; monitors pop expected write/done/pc_reset events.
// Define FETCH_CTRL_TIMEOUT_EN to also exercise the load watchdog.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       halt;

  logic       we1, me1, rd1, pce1, pcr1, done1, busy1, err1;
  logic [7:0] wd1, wa1;
  logic       we2, me2, rd2, pce2, pcr2, done2, busy2, err2;
  logic [7:0] wd2;
  logic [1:0] wa2;

  fetch_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_halt(halt), .o_write_enable(we1), .o_write_data(wd1), .o_write_addr(wa1),
    .o_instru_mem_enable(me1), .o_read_enable(rd1), .o_pc_enable(pce1),
    .o_pc_reset(pcr1), .o_load_done(done1), .o_busy(busy1), .o_error(err1)
  );

  fetch_ctrl #(.NB_IMEM_DEPTH(2), .TIMEOUT_CYCLES(16)) dut2 (
    .i_clock(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_halt(halt), .o_write_enable(we2), .o_write_data(wd2), .o_write_addr(wa2),
    .o_instru_mem_enable(me2), .o_read_enable(rd2), .o_pc_enable(pce2),
    .o_pc_reset(pcr2), .o_load_done(done2), .o_busy(busy2), .o_error(err2)
  );

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic       done;
    logic       pcr;
  } ev_t;

  ev_t        q1[$];
  ev_t        q2[$];
  logic [7:0] bq[$];
  int         m_addr = 0;
  int         checks = 0;
  int         failures = 0;
  int         pc_cnt = 0, rd_cnt = 0, pc_pulses = 0;
  logic       pce_prev = 1'b0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void cmp_ev(input string tag, input ev_t e, input logic we,
                                 input logic [7:0] wa, input logic [7:0] wd,
                                 input logic done, input logic pcr, input logic pce);
    check({tag, "_write_enable"}, {31'd0, we}, {31'd0, e.we});
    if (e.we) begin
      check({tag, "_write_addr"}, {24'd0, wa}, {24'd0, e.addr});
      check({tag, "_write_data"}, {24'd0, wd}, {24'd0, e.data});
      check({tag, "_pc_en_during_write"}, {31'd0, pce}, 32'd0);
    end
    check({tag, "_load_done"}, {31'd0, done}, {31'd0, e.done});
    check({tag, "_pc_reset"}, {31'd0, pcr}, {31'd0, e.pcr});
  endfunction

  function automatic void push_ev(input logic we, input logic [7:0] data, input logic done,
                                  input logic pcr);
    q1.push_back('{we, 8'(m_addr), data, done, pcr});
    q2.push_back('{we, 8'(m_addr % 4), data, done, pcr});
  endfunction

  // Monitor, default-depth instance.
  always @(negedge clk) begin
    if (we1 || done1 || pcr1) begin
      if (q1.size() == 0) check("dut_spurious_event", {29'd0, we1, done1, pcr1}, 32'd0);
      else cmp_ev("dut", q1.pop_front(), we1, wa1, wd1, done1, pcr1, pce1);
    end
  end

  // Monitor, 2-bit-address instance.
  always @(negedge clk) begin
    if (we2 || done2 || pcr2) begin
      if (q2.size() == 0) check("dut2_spurious_event", {29'd0, we2, done2, pcr2}, 32'd0);
      else cmp_ev("dut2", q2.pop_front(), we2, {6'd0, wa2}, wd2, done2, pcr2, pce2);
    end
  end

  // Program-counter activity counters.
  always @(negedge clk) begin
    if (pce1) pc_cnt <= pc_cnt + 1;
    if (rd1) rd_cnt <= rd_cnt + 1;
    if (pce1 && !pce_prev) pc_pulses <= pc_pulses + 1;
    pce_prev <= pce1;
  end

  // All stimulus tasks resume 1 time unit after a rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_load(input int n);
    send_byte(8'h4C);
    m_addr = 0;
    if (n == 0) push_ev(1'b0, 8'h00, 1'b1, 1'b0);
    send_byte(8'(n));
    for (int i = 0; i < 4 * n; i++) begin
      push_ev(1'b1, bq[i], i == 4 * n - 1, i == 4 * n - 1);
      m_addr++;
      send_byte(bq[i]);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_dut"}, {24'd0, we1, me1, rd1, pce1, pcr1, done1, busy1, err1}, 32'd0);
    check({name, "_dut_bus"}, {16'd0, wd1, wa1}, 32'd0);
    check({name, "_dut2"}, {22'd0, we2, me2, rd2, pce2, pcr2, done2, busy2, err2, wa2}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base_pc, base_rd, base_pulses;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    halt     = 1'b0;
    #3;
    check_idle_outputs("reset_before_clock");
    #9;
    check_idle_outputs("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);
    check("mem_enable_after_reset", {30'd0, me1, me2}, 32'd3);
    check("busy_after_reset", {30'd0, busy1, pce1}, 32'd0);

    // Basic one-word load.
    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_load(1);
    cycles(2);
    check("busy_after_load", {31'd0, busy1}, 32'd0);

    // 'X' in idle pulses pc_reset only.
    push_ev(1'b0, 8'h00, 1'b0, 1'b1);
    send_byte(8'h58);
    cycles(2);

    // Two-word load: dut2 wraps its address every four bytes.
    bq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    do_load(2);
    cycles(2);

    // Command bytes inside a load are plain data.
    bq = '{8'h4C, 8'h52, 8'h53, 8'h58};
    do_load(1);
    cycles(2);
    check("no_pc_after_cmd_data", {31'd0, pce1}, 32'd0);

    // Zero-length load.
    do_load(0);
    cycles(2);
    check("busy_after_zero_load", {31'd0, busy1}, 32'd0);

    // Run, halt sampled on the fifth edge after 'R'.
    base_pc = pc_cnt;
    base_rd = rd_cnt;
    send_byte(8'h52);
    check("busy_in_run", {31'd0, busy1}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    halt = 1'b1;
    cycles(1);
    halt = 1'b0;
    cycles(3);
    check("run_halt_pc_cycles", pc_cnt - base_pc, 32'd5);
    check("run_halt_rd_cycles", rd_cnt - base_rd, 32'd5);
    check("busy_after_halt", {31'd0, busy1}, 32'd0);

    // Run stopped by 'X' after three cycles.
    base_pc = pc_cnt;
    send_byte(8'h52);
    cycles(2);
    send_byte(8'h58);
    cycles(3);
    check("run_x_pc_cycles", pc_cnt - base_pc, 32'd3);
    check("busy_after_run_x", {31'd0, busy1}, 32'd0);

    // Three spaced steps.
    base_pc     = pc_cnt;
    base_pulses = pc_pulses;
    send_byte(8'h53);
    cycles(3);
    send_byte(8'h53);
    cycles(3);
    send_byte(8'h53);
    cycles(3);
    check("step_pc_cycles", pc_cnt - base_pc, 32'd3);
    check("step_pc_pulses", pc_pulses - base_pulses, 32'd3);

    // 'R' arriving during a step is ignored.
    base_pc = pc_cnt;
    send_byte(8'h53);
    send_byte(8'h52);
    cycles(3);
    check("step_ignores_byte", pc_cnt - base_pc, 32'd1);
    check("busy_after_step", {31'd0, busy1}, 32'd0);

    // Reset mid-load, then a fresh load from address 0.
    send_byte(8'h4C);
    m_addr = 0;
    send_byte(8'h01);
    push_ev(1'b1, 8'h11, 1'b0, 1'b0);
    m_addr++;
    send_byte(8'h11);
    push_ev(1'b1, 8'h22, 1'b0, 1'b0);
    m_addr++;
    send_byte(8'h22);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset_mid_load");
    cycles(2);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
    bq = '{8'h31, 8'h32, 8'h33, 8'h34};
    do_load(1);
    cycles(2);

`ifdef FETCH_CTRL_TIMEOUT_EN
    send_byte(8'h4C);
    cycles(15);
    check("wdog_before_expiry", {30'd0, busy1, err1}, 32'd2);
    cycles(1);
    check("wdog_expired", {30'd0, busy1, err1}, 32'd1);
    check("wdog_expired_dut2", {30'd0, busy2, err2}, 32'd1);
    send_byte(8'h4C);
    check("error_cleared_by_load", {30'd0, busy1, err1}, 32'd2);
    push_ev(1'b0, 8'h00, 1'b1, 1'b0);
    send_byte(8'h00);
    cycles(2);
`else
    check("error_tied_low", {30'd0, err1, err2}, 32'd0);
`endif

    cycles(3);
    check("dut_queue_drained", q1.size(), 32'd0);
    check("dut2_queue_drained", q2.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
